multi_monoflop: RTL and testbench
=================================

# multi_monoflop

Parametrised, multi-channel monoflop for the pulse-sequencer trigger fabric. Each channel detects a selectable edge on its trigger input, qualified by a per-channel enable, and emits a registered output pulse of programmable length in clock cycles. Optional retrigger, a per-channel accept strobe and sticky overrun flags let software observe lost triggers. With rising-edge mode and a length of 1, every channel matches the legacy single-cycle monoflop cycle for cycle.

## Interface
- CHANNELS, 8, number of independent channels (1..32)
- LEN_BITS, 16, width of the pulse-length value
- clk  in  1  system clock; all logic is on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- trigger  in  CHANNELS  raw trigger level per channel, synchronous to clk
- enable  in  CHANNELS  per-channel qualifier
- edge_mode  in  2  global edge select: RISE=00, FALL=01, BOTH=10, 11=no detection
- retrigger  in  1  global mode: 1 restarts an active pulse, 0 ignores the event
- pulse_len  in  LEN_BITS  global pulse length in cycles; 0 is treated as 1
- clear_overrun  in  CHANNELS  per-channel clear of the sticky overrun flag
- q  out  CHANNELS  pulse outputs (registered)
- fired  out  CHANNELS  one-cycle strobe for each accepted event (new or retriggered)
- overrun  out  CHANNELS  sticky flag: an event was ignored because the channel was active

## Operation
- Per channel i, define s = trigger[i] & enable[i]. The register prev[i] is loaded with s every cycle.
- Rise event: s & ~prev. Fall event: prev & ~trigger & enable. A fall event is never generated by enable deasserting.
- ev = the rise event, the fall event or (rise | fall), selected by edge_mode. When edge_mode is 11, ev = 0.
- Channel state: active[i] plus down-counter cnt[i] (LEN_BITS). q[i] = active[i].
- Idle and ev:
  - active <= 1
  - cnt <= max(pulse_len,1) - 1
  - fired <= 1
- Active, no ev: if cnt == 0 then active <= 0, else cnt <= cnt - 1.
- Active and ev with retrigger = 1: cnt reloads as above, active stays 1, fired <= 1. The pulse is extended with no gap.
- Active and ev with retrigger = 0: the event is dropped and overrun <= 1. This includes ev on the final cycle (cnt == 0).
- enable[i] low while active: the pulse runs to completion. enable only masks new events.
- pulse_len is sampled only when a pulse starts or is reloaded. Mid-pulse changes have no effect.
- overrun: a set in the same cycle as clear_overrun wins over the clear.

## Timing
- Reset (rst_n low, asynchronous): q = 0, fired = 0, overrun = 0, prev = 0, active = 0, cnt = 0. The first cycle after release with s = 1 counts as a rise event, as in the legacy block.
- Latency: an event sampled at clock edge k gives q high and fired high from edge k through k+L, where L = max(pulse_len,1). q stays high for exactly L cycles.
- fired is high for one cycle per accepted event. It is aligned with the first q cycle, or with the reload cycle on a retrigger.
- Minimum event spacing is 2 cycles, because prev is required to toggle. With retrigger = 0 and L = 1, the maximum rate is one pulse every 2 cycles.
- Reset asserted mid-pulse clears q immediately. No pulse resumes after release unless a new event occurs.
- Channels are fully independent. Simultaneous events on all channels must all be handled in the same cycle.

## Structure
- Package monoflop_pkg holds the EDGE_RISE, EDGE_FALL, EDGE_BOTH and EDGE_NONE constants and the edge_mode width.
- Sub-module monoflop_channel contains the prev, active, cnt, fired and overrun logic for one channel.
- The top level instantiates monoflop_channel CHANNELS times in a generate loop and broadcasts edge_mode, retrigger and pulse_len to all channels.

## Test plan
- Legacy check. Setup: RISE, pulse_len = 1, enable = 1, trigger 0→1 at edge 10 and held. Required: q high for one cycle from edge 10, fired high in the same cycle, no further pulses.
- Length and fall mode. Setup: FALL, pulse_len = 5, trigger 1→0. Required: q high for exactly 5 cycles. Setup: pulse_len = 0. Required: q high for 1 cycle.
- Retrigger. Setup: RISE, pulse_len = 10, retrigger = 1, second rise 4 cycles after the first. Required: q continuously high for 14 cycles, fired pulses twice, overrun stays 0.
- Overrun. Repeat the retrigger test with retrigger = 0. Required: q high for 10 cycles, fired pulses once, overrun = 1 until clear_overrun. A set and clear in the same cycle leaves overrun = 1.
- Enable and mode gating. Checks:
  - enable drops while trigger is high in FALL mode: no pulse.
  - enable rises while trigger is high in RISE mode: one pulse.
  - edge_mode = 11: no pulses.
  - enable drops mid-pulse: the pulse completes.
- Reset and independence. Setup: rst_n asserted mid-pulse. Required: q = 0 immediately. Setup: all 8 channels triggered in the same cycle with BOTH mode. Required: 8 identical pulses.

Source files
------------

// File: rtl/monoflop_pkg.sv
// Shared constants and types for the multi-channel monoflop.
// Edge-select encoding, channel state type and the edge-event selector.
package monoflop_pkg;

    localparam int EDGE_W = 2;

    typedef logic [EDGE_W-1:0] edge_mode_t;

    localparam edge_mode_t EDGE_RISE = 2'b00;
    localparam edge_mode_t EDGE_FALL = 2'b01;
    localparam edge_mode_t EDGE_BOTH = 2'b10;
    localparam edge_mode_t EDGE_NONE = 2'b11;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } ch_state_t;

    function automatic logic edge_event(input edge_mode_t mode, input logic rise,
                                        input logic fall);
        case (mode)
            EDGE_RISE: return rise;
            EDGE_FALL: return fall;
            EDGE_BOTH: return rise | fall;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multi_monoflop_if.sv
// Trigger/configuration/status bundle between the sequencer fabric and the monoflop bank.
// The master drives triggers and configuration; the slave returns pulses and status.
interface multi_monoflop_if
    import monoflop_pkg::*;
#(
    parameter int CHANNELS = 8,
    parameter int LEN_BITS = 16
);

    logic [CHANNELS-1:0] trigger;
    logic [CHANNELS-1:0] enable;
    edge_mode_t          edge_mode;
    logic                retrigger;
    logic [LEN_BITS-1:0] pulse_len;
    logic [CHANNELS-1:0] clear_overrun;
    logic [CHANNELS-1:0] q;
    logic [CHANNELS-1:0] fired;
    logic [CHANNELS-1:0] overrun;

    modport master (
        output trigger, enable, edge_mode, retrigger, pulse_len, clear_overrun,
        input  q, fired, overrun
    );

    modport slave (
        input  trigger, enable, edge_mode, retrigger, pulse_len, clear_overrun,
        output q, fired, overrun
    );

endinterface

// File: rtl/monoflop_channel.sv
// One monoflop channel: edge detect, pulse down-counter, accept strobe and sticky overrun.
//   state     | meaning
//   ST_IDLE   | q low, waiting for a qualified edge
//   ST_ACTIVE | q high, cnt counts the remaining cycles after this one
module monoflop_channel
    import monoflop_pkg::*;
#(
    parameter int LEN_BITS = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                trigger,
    input  logic                enable,
    input  edge_mode_t          edge_mode,
    input  logic                retrigger,
    input  logic [LEN_BITS-1:0] pulse_len,
    input  logic                clear_overrun,
    output logic                q,
    output logic                fired,
    output logic                overrun
);

    ch_state_t           state, state_nxt;
    logic [LEN_BITS-1:0] cnt, cnt_nxt, load_val;
    logic                prev;
    logic                fired_r, fired_nxt;
    logic                ovr_r, ovr_nxt, ovr_set;
    logic                s, rise, fall, ev;

    assign s    = trigger & enable;
    assign rise = s & ~prev;
    // A fall needs enable high now, so dropping enable never looks like a falling edge.
    assign fall = prev & ~trigger & enable;
    assign ev   = edge_event(edge_mode, rise, fall);

    assign load_val = (pulse_len == '0) ? '0 : pulse_len - LEN_BITS'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            prev    <= 1'b0;
            fired_r <= 1'b0;
            ovr_r   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            prev    <= s;
            fired_r <= fired_nxt;
            ovr_r   <= ovr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        fired_nxt = 1'b0;
        ovr_set   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ev) begin
                    state_nxt = ST_ACTIVE;
                    cnt_nxt   = load_val;
                    fired_nxt = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (ev && retrigger) begin
                    cnt_nxt   = load_val;
                    fired_nxt = 1'b1;
                end else begin
                    // A dropped event still lets the running pulse count down normally.
                    ovr_set = ev;
                    if (cnt == '0) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        cnt_nxt = cnt - LEN_BITS'(1);
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        ovr_nxt = ovr_set | (ovr_r & ~clear_overrun);
    end

    always_comb begin
        q       = (state == ST_ACTIVE);
        fired   = fired_r;
        overrun = ovr_r;
    end

endmodule

// File: rtl/multi_monoflop.sv
// Bank of independent monoflop channels sharing edge mode, retrigger mode and pulse length.
module multi_monoflop
    import monoflop_pkg::*;
#(
    parameter int CHANNELS = 8,
    parameter int LEN_BITS = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    multi_monoflop_if.slave    bus
);

    logic [CHANNELS-1:0] q_v;
    logic [CHANNELS-1:0] fired_v;
    logic [CHANNELS-1:0] ovr_v;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        monoflop_channel #(
            .LEN_BITS (LEN_BITS)
        ) u_ch (
            .clk           (clk),
            .rst_n         (rst_n),
            .trigger       (bus.trigger[i]),
            .enable        (bus.enable[i]),
            .edge_mode     (bus.edge_mode),
            .retrigger     (bus.retrigger),
            .pulse_len     (bus.pulse_len),
            .clear_overrun (bus.clear_overrun[i]),
            .q             (q_v[i]),
            .fired         (fired_v[i]),
            .overrun       (ovr_v[i])
        );
    end

    assign bus.q       = q_v;
    assign bus.fired   = fired_v;
    assign bus.overrun = ovr_v;

endmodule

// File: tb/tb_multi_monoflop.sv
// Self-checking bench for multi_monoflop: vector table, directed corner sequences and
// randomized traffic against a remaining-cycles reference model.
module tb_multi_monoflop;

    localparam int CH = 8;
    localparam int LB = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multi_monoflop_if #(.CHANNELS(CH), .LEN_BITS(LB)) bus ();

    multi_monoflop #(.CHANNELS(CH), .LEN_BITS(LB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: each channel holds the number of q-high cycles still owed.
    int            rem [CH];
    logic          m_prev [CH];
    logic [CH-1:0] m_q, m_fired, m_ovr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            rem[i]    = 0;
            m_prev[i] = 1'b0;
        end
        m_q = '0; m_fired = '0; m_ovr = '0;
    endtask

    task automatic model_clock();
        int   len;
        logic s, rise, fall, ev, set;
        len = (bus.pulse_len == 0) ? 1 : int'(bus.pulse_len);
        for (int i = 0; i < CH; i++) begin
            s    = bus.trigger[i] & bus.enable[i];
            rise = s & ~m_prev[i];
            fall = m_prev[i] & ~bus.trigger[i] & bus.enable[i];
            case (bus.edge_mode)
                2'b00:   ev = rise;
                2'b01:   ev = fall;
                2'b10:   ev = rise | fall;
                default: ev = 1'b0;
            endcase
            m_prev[i]  = s;
            m_fired[i] = 1'b0;
            set        = 1'b0;
            if (rem[i] == 0) begin
                if (ev) begin rem[i] = len; m_fired[i] = 1'b1; end
            end else if (ev && bus.retrigger) begin
                rem[i] = len; m_fired[i] = 1'b1;
            end else begin
                set    = ev;
                rem[i] = rem[i] - 1;
            end
            m_ovr[i] = set | (m_ovr[i] & ~bus.clear_overrun[i]);
            m_q[i]   = (rem[i] > 0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_clock();
        #1;
        check("model_q", 32'(bus.q), 32'(m_q));
        check("model_fired", 32'(bus.fired), 32'(m_fired));
        check("model_overrun", 32'(bus.overrun), 32'(m_ovr));
    endtask

    task automatic set_in(input logic [CH-1:0] trig, input logic [CH-1:0] en,
                          input logic [1:0] mode, input logic retrig, input logic [LB-1:0] len);
        bus.trigger   = trig;
        bus.enable    = en;
        bus.edge_mode = mode;
        bus.retrigger = retrig;
        bus.pulse_len = len;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_in('0, '0, 2'b00, 1'b0, '0);
        bus.clear_overrun = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_q", 32'(bus.q), 32'h0);
        check("reset_fired", 32'(bus.fired), 32'h0);
        check("reset_overrun", 32'(bus.overrun), 32'h0);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [CH-1:0] trig;
        logic [CH-1:0] en;
        logic [1:0]    mode;
        logic          retrig;
        logic [LB-1:0] len;
        logic [CH-1:0] clr;
        logic [CH-1:0] eq;
        logic [CH-1:0] ef;
        logic [CH-1:0] eo;
    } vec_t;

    vec_t tbl[$];

    // Runs a two-rise sequence on all channels, second rise 4 cycles after the first.
    task automatic two_rises(input logic retrig, output int highs, output int fires,
                             output int span);
        int first, last;
        highs = 0; fires = 0; first = -1; last = -1;
        set_in('0, '1, 2'b00, retrig, 16'd10);
        step();
        for (int c = 0; c < 25; c++) begin
            bus.trigger = (c == 0 || c == 1 || c >= 4) ? '1 : '0;
            step();
            if (bus.q[0]) begin
                highs++;
                if (first < 0) first = c;
                last = c;
            end
            if (bus.fired[0]) fires++;
        end
        span = (first < 0) ? 0 : last - first + 1;
    endtask

    int highs, fires, span, full;

    initial begin
        bus.clear_overrun = '0;
        set_in('0, '0, 2'b00, 1'b0, '0);
        do_reset();

        // trig, en, mode, retrig, len, clr, exp q, exp fired, exp overrun
        tbl.push_back('{8'h00, 8'hFF, 2'b00, 1'b0, 16'd1, 8'h00, 8'h00, 8'h00, 8'h00});
        tbl.push_back('{8'hFF, 8'hFF, 2'b00, 1'b0, 16'd1, 8'h00, 8'hFF, 8'hFF, 8'h00});
        tbl.push_back('{8'hFF, 8'hFF, 2'b00, 1'b0, 16'd1, 8'h00, 8'h00, 8'h00, 8'h00});
        tbl.push_back('{8'hFF, 8'hFF, 2'b00, 1'b0, 16'd1, 8'h00, 8'h00, 8'h00, 8'h00});
        tbl.push_back('{8'h00, 8'hFF, 2'b00, 1'b0, 16'd1, 8'h00, 8'h00, 8'h00, 8'h00});
        tbl.push_back('{8'h0F, 8'hFF, 2'b00, 1'b0, 16'd1, 8'h00, 8'h0F, 8'h0F, 8'h00});
        tbl.push_back('{8'h00, 8'hFF, 2'b00, 1'b0, 16'd3, 8'h00, 8'h00, 8'h00, 8'h00});
        tbl.push_back('{8'h01, 8'hFF, 2'b00, 1'b0, 16'd3, 8'h00, 8'h01, 8'h01, 8'h00});
        tbl.push_back('{8'h00, 8'hFF, 2'b00, 1'b0, 16'd3, 8'h00, 8'h01, 8'h00, 8'h00});
        tbl.push_back('{8'h01, 8'hFF, 2'b00, 1'b0, 16'd3, 8'h00, 8'h01, 8'h00, 8'h01});
        tbl.push_back('{8'h01, 8'hFF, 2'b00, 1'b0, 16'd3, 8'h00, 8'h00, 8'h00, 8'h01});
        tbl.push_back('{8'h01, 8'hFF, 2'b00, 1'b0, 16'd3, 8'h01, 8'h00, 8'h00, 8'h00});
        tbl.push_back('{8'h00, 8'hFF, 2'b00, 1'b0, 16'd0, 8'h00, 8'h00, 8'h00, 8'h00});
        tbl.push_back('{8'h10, 8'hFF, 2'b00, 1'b0, 16'd0, 8'h00, 8'h10, 8'h10, 8'h00});
        tbl.push_back('{8'h10, 8'hFF, 2'b00, 1'b0, 16'd0, 8'h00, 8'h00, 8'h00, 8'h00});

        foreach (tbl[k]) begin
            set_in(tbl[k].trig, tbl[k].en, tbl[k].mode, tbl[k].retrig, tbl[k].len);
            bus.clear_overrun = tbl[k].clr;
            step();
            check($sformatf("tbl%0d_q", k), 32'(bus.q), 32'(tbl[k].eq));
            check($sformatf("tbl%0d_fired", k), 32'(bus.fired), 32'(tbl[k].ef));
            check($sformatf("tbl%0d_overrun", k), 32'(bus.overrun), 32'(tbl[k].eo));
        end
        bus.clear_overrun = '0;

        // Falling edge, length 5 then length 0.
        do_reset();
        set_in('1, '1, 2'b01, 1'b0, 16'd5);
        step(); step();
        bus.trigger = '0;
        highs = 0;
        for (int c = 0; c < 10; c++) begin step(); if (bus.q[0]) highs++; end
        check("fall_len5_cycles", 32'(highs), 32'd5);
        bus.trigger = '1; bus.pulse_len = 16'd0;
        step();
        bus.trigger = '0;
        highs = 0;
        for (int c = 0; c < 6; c++) begin step(); if (bus.q[0]) highs++; end
        check("fall_len0_cycles", 32'(highs), 32'd1);

        // Retrigger extends with no gap; without retrigger the event is lost.
        do_reset();
        two_rises(1'b1, highs, fires, span);
        check("retrig_high_cycles", 32'(highs), 32'd14);
        check("retrig_contiguous", 32'(span), 32'd14);
        check("retrig_fired_count", 32'(fires), 32'd2);
        check("retrig_overrun", 32'(bus.overrun[0]), 32'd0);
        do_reset();
        two_rises(1'b0, highs, fires, span);
        check("noretrig_high_cycles", 32'(highs), 32'd10);
        check("noretrig_fired_count", 32'(fires), 32'd1);
        check("noretrig_overrun", 32'(bus.overrun[0]), 32'd1);
        bus.trigger = '0; step();
        bus.trigger = '1; step();
        bus.trigger = '0; step();
        bus.trigger = '1; bus.clear_overrun = '1; step();
        check("set_beats_clear", 32'(bus.overrun[0]), 32'd1);
        step();
        check("clear_overrun", 32'(bus.overrun[0]), 32'd0);
        bus.clear_overrun = '0;

        // Enable and mode gating.
        do_reset();
        set_in('1, '1, 2'b01, 1'b0, 16'd3);
        step(); step();
        bus.enable = '0; step();
        bus.trigger = '0; step();
        bus.enable = '1;
        highs = 0;
        for (int c = 0; c < 6; c++) begin step(); if (bus.q[0]) highs++; end
        check("fall_enable_drop", 32'(highs), 32'd0);
        set_in('1, '0, 2'b00, 1'b0, 16'd3);
        step(); step();
        bus.enable = '1;
        highs = 0;
        for (int c = 0; c < 6; c++) begin step(); if (bus.q[0]) highs++; end
        check("rise_enable_rise", 32'(highs), 32'd3);
        set_in('0, '1, 2'b11, 1'b1, 16'd2);
        highs = 0;
        for (int c = 0; c < 12; c++) begin
            bus.trigger = (c % 2 == 0) ? '1 : '0;
            step();
            if (bus.q != '0) highs++;
        end
        check("mode_none_pulses", 32'(highs), 32'd0);
        set_in('0, '1, 2'b00, 1'b0, 16'd6);
        step();
        bus.trigger = '1;
        step();
        highs = bus.q[0] ? 1 : 0;
        bus.enable = '0;
        for (int c = 0; c < 8; c++) begin step(); if (bus.q[0]) highs++; end
        check("enable_drop_midpulse", 32'(highs), 32'd6);

        // Reset mid-pulse clears q at once; nothing resumes after release.
        set_in('0, '1, 2'b00, 1'b0, 16'd10);
        step();
        bus.trigger = '1;
        step(); step(); step();
        check("pre_reset_q", 32'(bus.q), 32'hFF);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_reset_q", 32'(bus.q), 32'h0);
        @(posedge clk); #1;
        bus.trigger = '0;
        rst_n = 1'b1;
        highs = 0;
        for (int c = 0; c < 6; c++) begin step(); if (bus.q != '0) highs++; end
        check("no_resume_after_reset", 32'(highs), 32'd0);

        // All channels at once in BOTH mode.
        set_in('0, '1, 2'b10, 1'b0, 16'd4);
        step();
        full = 0;
        for (int c = 0; c < 16; c++) begin
            bus.trigger = (c < 8) ? '1 : '0;
            step();
            if (bus.q == '1) full++;
            else if (bus.q != '0) check("all_channels_identical", 32'(bus.q), 32'hFF);
        end
        check("all_channels_both_edges", 32'(full), 32'd8);

        // Randomized traffic against the model.
        do_reset();
        set_in('0, '1, 2'b00, 1'b0, 16'd2);
        for (int c = 0; c < 3000; c++) begin
            if (c % 50 == 0) begin
                bus.edge_mode = 2'($urandom_range(0, 3));
                bus.retrigger = 1'($urandom_range(0, 1));
            end
            if (c % 7 == 0) bus.pulse_len = 16'($urandom_range(0, 6));
            bus.trigger       = bus.trigger ^ CH'($urandom & $urandom & $urandom);
            bus.enable        = CH'($urandom | $urandom);
            bus.clear_overrun = CH'($urandom & $urandom & $urandom & $urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
